// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage feeding the decoder. Owns the program counter,
// issues one request at a time to a variable-latency instruction memory,
// holds the returned word for the decoder until it is consumed, then
// computes the next PC from the decoder's branch/jump outcome.
//
// State table:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_FETCH | request outstanding at pc_o, waiting for imem_ack
//   ST_HOLD  | instr presented to decoder, waiting for instr_ready
//   ST_FAULT | a computed PC was misaligned; frozen until rst
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   imem_req      fetch request (state decode gated by rst)
//   imem_addr     fetch address, always equal to pc_o
//   imem_ack      one-cycle response strobe, imem_rdata valid with it
//   imem_rdata    fetched instruction word
//   instr         registered instruction to the decoder
//   instr_valid   instr holds an unconsumed instruction
//   instr_ready   decoder consumes instr this cycle when instr_valid=1
//   pc_o          address of the current instruction
//   PCPlus4       pc_o + 4 for link writes
//   PCSrc         branch taken, target pc_o + Imm_i
//   JRetSrc       register-indirect jump, target (RD1_i + Imm_i) & ~1
//   Imm_i, RD1_i  immediate and rs1 operand from the decoder
//   misaligned    sticky fault flag
//   instret       consumed-instruction count, wraps
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                     DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    input  logic                  PCSrc,
    input  logic                  JRetSrc,
    input  logic [DATA_WIDTH-1:0] Imm_i,
    input  logic [DATA_WIDTH-1:0] RD1_i,
    output logic                  misaligned,
    output logic [DATA_WIDTH-1:0] instret
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic                  r_misaligned;
    logic [DATA_WIDTH-1:0] r_instret;

    logic                  w_fetch_done;
    logic                  w_consume;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_br_target;
    logic [DATA_WIDTH-1:0] w_jr_sum;
    logic [DATA_WIDTH-1:0] w_jr_target;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_next_bad;
    logic                  w_req;

    // Handshake qualifiers. An ack outside ST_FETCH is simply not seen.
    assign w_fetch_done = (r_state == ST_FETCH) && imem_ack;
    assign w_consume    = (r_state == ST_HOLD) && instr_ready;

    // Next-PC candidates; all sums wrap at DATA_WIDTH bits.
    assign w_pc_plus4  = r_pc + DATA_WIDTH'(4);
    assign w_br_target = r_pc + Imm_i;
    assign w_jr_sum    = RD1_i + Imm_i;
    assign w_jr_target = {w_jr_sum[DATA_WIDTH-1:1], 1'b0};

    // Indirect jump wins over a taken branch when both are asserted.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (JRetSrc) begin
            w_next_pc = w_jr_target;
        end else if (PCSrc) begin
            w_next_pc = w_br_target;
        end
    end

    assign w_next_bad = |w_next_pc[1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ack) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    w_state_nxt = w_next_bad ? ST_FAULT : ST_FETCH;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. The request depends only on the state register and
    // rst, so there is no combinational path from the memory side.
    // ------------------------------------------------------------------
    always_comb begin
        w_req = 1'b0;
        if (!rst && (r_state == ST_FETCH)) begin
            w_req = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_instret     <= '0;
        end else begin
            if (w_fetch_done) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_consume) begin
                r_instr_valid <= 1'b0;
                r_pc          <= w_next_pc;
                r_instret     <= r_instret + DATA_WIDTH'(1);
                // The bad PC is still committed so it can be inspected.
                if (w_next_bad) begin
                    r_misaligned <= 1'b1;
                end
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_o        = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign misaligned  = r_misaligned;
    assign instret     = r_instret;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_o;
    logic [31:0] PCPlus4;
    logic        PCSrc;
    logic        JRetSrc;
    logic [31:0] Imm_i;
    logic [31:0] RD1_i;
    logic        misaligned;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_o        (pc_o),
        .PCPlus4     (PCPlus4),
        .PCSrc       (PCSrc),
        .JRetSrc     (JRetSrc),
        .Imm_i       (Imm_i),
        .RD1_i       (RD1_i),
        .misaligned  (misaligned),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: no checking inside. Both start and end at a negedge.
    task automatic fetch_word(input int delay, input logic [31:0] word);
        repeat (delay) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
    endtask

    task automatic do_consume(input logic pcsrc, input logic jret,
                              input logic [31:0] imm, input logic [31:0] rd1);
        instr_ready = 1'b1;
        PCSrc       = pcsrc;
        JRetSrc     = jret;
        Imm_i       = imm;
        RD1_i       = rd1;
        @(negedge clk);
        instr_ready = 1'b0;
        PCSrc       = 1'b1;
        JRetSrc     = 1'b1;
        Imm_i       = 32'h1234_5677;
        RD1_i       = 32'h0BAD_F00D;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_o); end
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL rst_instret got %h exp 0", instret); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rst_misaligned got %0b exp 0", misaligned); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %0b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early got %0b exp 0", instr_valid); end
        fetch_word(0, 32'h0050_0093);
        checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL first_instr got %h exp 00500093", instr); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b exp 1", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got %0b exp 0", imem_req); end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL bp_instr[%0d] got %h exp 00500093", i, instr); end
            checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL bp_pc[%0d] got %h exp 0", i, pc_o); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b exp 1", i, instr_valid); end
        end
        do_consume(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (instret !== 32'd1) begin errors++; $display("FAIL seq_instret got %0d exp 1", instret); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req got %0b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr got %h exp 4", imem_addr); end
        checks++; if (PCPlus4 !== 32'h8) begin errors++; $display("FAIL seq_pcplus4 got %h exp 8", PCPlus4); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid got %0b exp 0", instr_valid); end
    endtask

    task automatic test_branch_jump;
        // Walk sequentially 0x4 -> 0x8 -> 0xC -> 0x10.
        for (int i = 0; i < 3; i++) begin
            fetch_word(0, 32'h0000_0013);
            do_consume(1'b0, 1'b0, 32'h0, 32'h0);
        end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL walk_addr got %h exp 10", imem_addr); end
        fetch_word(0, 32'hFE00_0CE3);
        do_consume(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
        checks++; if (imem_addr !== 32'h08) begin errors++; $display("FAIL branch_addr got %h exp 08", imem_addr); end
        fetch_word(0, 32'h0030_8067);
        do_consume(1'b1, 1'b1, 32'h3, 32'h101);
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL jalr_addr got %h exp 104", imem_addr); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL jalr_misaligned got %0b exp 0", misaligned); end
        checks++; if (instret !== 32'd6) begin errors++; $display("FAIL bj_instret got %0d exp 6", instret); end
    endtask

    task automatic test_variable_latency;
        int          delays [3];
        logic [31:0] words  [3];
        logic [31:0] exp_pc;
        delays = '{0, 1, 7};
        words  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        exp_pc = 32'h104;
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < delays[k]; w++) begin
                @(negedge clk);
                checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL lat_req[%0d.%0d] got %0b exp 1", k, w, imem_req); end
                checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL lat_addr[%0d.%0d] got %h exp %h", k, w, imem_addr, exp_pc); end
            end
            imem_ack   = 1'b1;
            imem_rdata = words[k];
            @(negedge clk);
            imem_ack   = 1'b0;
            checks++; if (instr !== words[k]) begin errors++; $display("FAIL lat_instr[%0d] got %h exp %h", k, instr, words[k]); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL lat_valid[%0d] got %0b exp 1", k, instr_valid); end
            // A stray ack while holding must not overwrite the word.
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            imem_ack   = 1'b0;
            checks++; if (instr !== words[k]) begin errors++; $display("FAIL stray_ack_instr[%0d] got %h exp %h", k, instr, words[k]); end
            do_consume(1'b0, 1'b0, 32'h0, 32'h0);
            exp_pc = exp_pc + 32'h4;
        end
        checks++; if (imem_addr !== 32'h110) begin errors++; $display("FAIL lat_final_addr got %h exp 110", imem_addr); end
        checks++; if (instret !== 32'd9) begin errors++; $display("FAIL lat_instret got %0d exp 9", instret); end
    endtask

    task automatic test_wrap;
        fetch_word(0, 32'h0000_0067);
        do_consume(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFD);
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", pc_o); end
        checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 got %h exp 0", PCPlus4); end
        fetch_word(1, 32'h0000_0013);
        do_consume(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL wrap_misaligned got %0b exp 0", misaligned); end
    endtask

    task automatic test_misaligned;
        apply_reset(1);
        fetch_word(0, 32'h0000_0067);
        do_consume(1'b0, 1'b1, 32'h0, 32'h20);
        checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL mis_setup_addr got %h exp 20", imem_addr); end
        fetch_word(0, 32'h0000_0163);
        do_consume(1'b1, 1'b0, 32'h2, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) imem_ack = 1'b1;
            @(negedge clk);
            imem_ack = 1'b0;
            checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL fault_flag[%0d] got %0b exp 1", i, misaligned); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fault_req[%0d] got %0b exp 0", i, imem_req); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fault_valid[%0d] got %0b exp 0", i, instr_valid); end
        end
        checks++; if (pc_o !== 32'h22) begin errors++; $display("FAIL fault_pc got %h exp 22", pc_o); end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        checks++; if (instret !== 32'd2) begin errors++; $display("FAIL fault_instret got %0d exp 2", instret); end
        apply_reset(1);
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL clr_misaligned got %0b exp 0", misaligned); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL clr_req got %0b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL clr_addr got %h exp 0", imem_addr); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL clr_instret got %0d exp 0", instret); end
    endtask

    task automatic test_reset_mid_fetch;
        fetch_word(0, 32'h0000_0013);
        do_consume(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL mid_setup_addr got %h exp 4", imem_addr); end
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req_gated got %0b exp 0", imem_req); end
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL mid_instr got %h exp 0", instr); end
        checks++; if (instret !== 32'h0) begin errors++; $display("FAIL mid_instret got %0d exp 0", instret); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_restart_req got %0b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart_addr got %h exp 0", imem_addr); end
        fetch_word(2, 32'h00C0_006F);
        checks++; if (instr !== 32'h00C0_006F) begin errors++; $display("FAIL mid_refetch_instr got %h exp 00c0006f", instr); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL mid_refetch_valid got %0b exp 1", instr_valid); end
    endtask

    task automatic test_back_to_back;
        // Zero-wait memory with ready high: valid alternates 1,0,1,0.
        logic [31:0] exp_pc;
        do_consume(1'b0, 1'b0, 32'h0, 32'h0);
        exp_pc = 32'h4;
        for (int i = 0; i < 3; i++) begin
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_low[%0d] got %0b exp 0", i, instr_valid); end
            checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL b2b_addr[%0d] got %h exp %h", i, imem_addr, exp_pc); end
            fetch_word(0, 32'h0000_0013);
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_high[%0d] got %0b exp 1", i, instr_valid); end
            do_consume(1'b0, 1'b0, 32'h0, 32'h0);
            exp_pc = exp_pc + 32'h4;
        end
        checks++; if (instret !== 32'd4) begin errors++; $display("FAIL b2b_instret got %0d exp 4", instret); end
    endtask

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        JRetSrc     = 1'b0;
        Imm_i       = 32'h0;
        RD1_i       = 32'h0;
        test_reset();
        test_backpressure();
        test_branch_jump();
        test_variable_latency();
        test_wrap();
        test_misaligned();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
